// File: rtl/io_pkg.sv
// Shared definitions for the zed_io switch/button block: default source widths
// and the interrupt-line FSM encoding.
package io_pkg;

  localparam int SW_W_DEF  = 8;
  localparam int BTN_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ASSERT = 2'b01,
    ST_GAP    = 2'b10
  } irq_state_e;

endpackage

// File: rtl/io_edge_det.sv
// Rising/falling edge detector for a vector of synchronous levels. Edges are
// suppressed until the history register has been primed after reset.
module io_edge_det #(
  parameter int W = 8
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  input  logic [W-1:0] d,
  input  logic         primed,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] prev;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      prev <= '0;
    end else begin
      prev <= d;
    end
  end

  // prev holds reset zeros until the first clock; gating on primed hides that.
  assign rise = primed ? (d & ~prev) : '0;
  assign fall = primed ? (~d & prev) : '0;

endmodule

// File: rtl/io_irq_ctrl.sv
// Switch/button interrupt controller: edge-triggered pending bits, a software
// test interrupt and a level IRQ with a guaranteed low gap after each service.
module io_irq_ctrl
  import io_pkg::*;
#(
  parameter int SW_W    = SW_W_DEF,
  parameter int BTN_W   = BTN_W_DEF,
  parameter int IRQ_GAP = 4
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic [SW_W-1:0]  switch,
  input  logic [BTN_W-1:0] button,
  input  logic [SW_W-1:0]  int_switch_ena,
  input  logic [SW_W-1:0]  int_switch_clr,
  input  logic [BTN_W-1:0] int_button_ena,
  input  logic [BTN_W-1:0] int_button_clr,
  input  logic [BTN_W-1:0] button_posedge,
  input  logic [BTN_W-1:0] button_negedge,
  input  logic             invoke_int_test,
  output logic [SW_W-1:0]  int_switch_sts,
  output logic [BTN_W-1:0] int_button_sts,
  output logic             irq
);

  localparam int CNT_W = $clog2(IRQ_GAP + 1);

  logic             primed;
  logic [SW_W-1:0]  sw_rise, sw_fall, sw_evt;
  logic [BTN_W-1:0] btn_rise, btn_fall, btn_evt;
  logic [SW_W-1:0]  sw_pend, sw_pend_nxt;
  logic [BTN_W-1:0] btn_pend, btn_pend_nxt;
  logic             test_pend, test_pend_nxt;
  logic             active;
  irq_state_e       state, state_nxt;
  logic [CNT_W-1:0] gap_cnt, gap_cnt_nxt;

  io_edge_det #(.W(SW_W)) u_sw_edge (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .d       (switch),
    .primed  (primed),
    .rise    (sw_rise),
    .fall    (sw_fall)
  );

  io_edge_det #(.W(BTN_W)) u_btn_edge (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .d       (button),
    .primed  (primed),
    .rise    (btn_rise),
    .fall    (btn_fall)
  );

  assign sw_evt  = sw_rise | sw_fall;
  assign btn_evt = (btn_rise & button_posedge) | (btn_fall & button_negedge);

  // Set terms are OR-ed in after the clear so an event coinciding with a clear survives.
  always_comb begin
    sw_pend_nxt   = (sw_pend & ~int_switch_clr) | (sw_evt & int_switch_ena);
    btn_pend_nxt  = (btn_pend & ~int_button_clr) | (btn_evt & int_button_ena);
    test_pend_nxt = test_pend;
    if (|int_switch_clr || |int_button_clr) begin
      test_pend_nxt = 1'b0;
    end
    if (invoke_int_test) begin
      test_pend_nxt = 1'b1;
    end
  end

  assign active = (|(sw_pend & int_switch_ena)) | (|(btn_pend & int_button_ena)) | test_pend;

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    unique case (state)
      ST_IDLE: begin
        if (active) begin
          state_nxt = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (!active) begin
          state_nxt   = ST_GAP;
          gap_cnt_nxt = CNT_W'(IRQ_GAP - 1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = active ? ST_ASSERT : ST_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        gap_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      primed    <= 1'b0;
      sw_pend   <= '0;
      btn_pend  <= '0;
      test_pend <= 1'b0;
      state     <= ST_IDLE;
      gap_cnt   <= '0;
      irq       <= 1'b0;
    end else begin
      primed    <= 1'b1;
      sw_pend   <= sw_pend_nxt;
      btn_pend  <= btn_pend_nxt;
      test_pend <= test_pend_nxt;
      state     <= state_nxt;
      gap_cnt   <= gap_cnt_nxt;
      irq       <= (state_nxt == ST_ASSERT);
    end
  end

  assign int_switch_sts = sw_pend;
  assign int_button_sts = btn_pend;

endmodule
